// File: rtl/memory_stage.sv
// memory_stage: memory-access pipeline stage with data memory, stack pointer and two-cycle PC push/pop
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   memRead, memWrite            load / store at aluData[ADDR_W-1:0]
//   push, pop                    16-bit stack push of storeData / pop to register
//   pcPush, pcPop                32-bit PC push (CALL/INT) / pop (RET/RTI), two cycles each
//   aluData, storeData, pcIn     address or ALU result, store data, return PC
//   wbIn, rDstIn                 write-back enable and destination register from EX/MEM
//   aluDataOut, rDstOut          pass-throughs to IM_IW
//   memoryDataOut, memoryReadOut read data and its valid / write-back select
//   wbOut                        write-back enable, forced low during PC operations
//   writePcLowOut/HighOut        memoryDataOut carries PC[15:0] / PC[31:16]
//   stall                        freeze upstream stages this cycle
//   spOut                        current stack pointer
module memory_stage #(
   parameter int ADDR_W = 11,
   parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic              push,
   input  logic              pop,
   input  logic              pcPush,
   input  logic              pcPop,
   input  logic [15:0]       aluData,
   input  logic [15:0]       storeData,
   input  logic [31:0]       pcIn,
   input  logic              wbIn,
   input  logic [2:0]        rDstIn,
   output logic [15:0]       aluDataOut,
   output logic [15:0]       memoryDataOut,
   output logic              memoryReadOut,
   output logic              wbOut,
   output logic [2:0]        rDstOut,
   output logic              writePcLowOut,
   output logic              writePcHighOut,
   output logic              stall,
   output logic [ADDR_W-1:0] spOut
);

   typedef enum logic [1:0] {IDLE, PUSH2, POP2} state_t;

   state_t            state, nextState;
   logic [ADDR_W-1:0] sp, nextSp, spInc, spDec, addr, wAddr, rdAddr;
   logic [15:0]       mem [2**ADDR_W];
   logic [15:0]       pcLow, wData;
   logic              memWe, rdEn, latchEn;

   assign spInc      = sp + 1'b1;
   assign spDec      = sp - 1'b1;
   assign addr       = aluData[ADDR_W-1:0];
   assign aluDataOut = aluData;
   assign rDstOut    = rDstIn;
   assign spOut      = sp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sp    <= SP_RESET;
      end else begin
         state <= nextState;
         sp    <= nextSp;
      end
   end

   // Low PC word waits here for the PUSH2 write; memory is never reset
   always_ff @(posedge clk) begin
      if (!rst && latchEn) pcLow <= pcIn[15:0];
      if (!rst && memWe) mem[wAddr] <= wData;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    nextState = pcPop ? POP2 : pcPush ? PUSH2 : IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      nextSp         = sp;
      memWe          = 1'b0;
      wAddr          = sp;
      wData          = storeData;
      rdEn           = 1'b0;
      rdAddr         = spInc;
      latchEn        = 1'b0;
      writePcLowOut  = 1'b0;
      writePcHighOut = 1'b0;
      stall          = 1'b0;
      wbOut          = 1'b0;
      case (state)
         IDLE: begin
            if (pcPop) begin
               rdEn          = 1'b1;
               writePcLowOut = 1'b1;
               nextSp        = spInc;
               stall         = 1'b1;
            end else if (pcPush) begin
               memWe   = 1'b1;
               wData   = pcIn[31:16];
               nextSp  = spDec;
               latchEn = 1'b1;
               stall   = 1'b1;
            end else begin
               wbOut = wbIn;
               if (pop) begin
                  rdEn   = 1'b1;
                  nextSp = spInc;
               end else if (push) begin
                  memWe  = 1'b1;
                  nextSp = spDec;
               end else if (memWrite) begin
                  memWe = 1'b1;
                  wAddr = addr;
               end else if (memRead) begin
                  rdEn   = 1'b1;
                  rdAddr = addr;
               end
            end
         end
         PUSH2: begin
            memWe  = 1'b1;
            wData  = pcLow;
            nextSp = spDec;
         end
         POP2: begin
            rdEn           = 1'b1;
            writePcHighOut = 1'b1;
            nextSp         = spInc;
         end
         default: ;
      endcase
   end

   assign memoryReadOut = rdEn;
   assign memoryDataOut = rdEn ? mem[rdAddr] : 16'h0000;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed plus random checks of memory_stage against an array-and-counter stack model
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst, memRead, memWrite, push, pop, pcPush, pcPop, wbIn;
   logic [15:0] aluData, storeData;
   logic [31:0] pcIn;
   logic [2:0]  rDstIn;
   logic [15:0] aluDataOut, memoryDataOut;
   logic        memoryReadOut, wbOut, writePcLowOut, writePcHighOut, stall;
   logic [2:0]  rDstOut;
   logic [10:0] spOut;

   int          compared = 0;
   int          mismatched = 0;
   int          sp;
   logic [15:0] mm [2048];
   bit          kn [2048];

   memory_stage #(.ADDR_W(11)) dut (
      .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .push(push), .pop(pop),
      .pcPush(pcPush), .pcPop(pcPop), .aluData(aluData), .storeData(storeData), .pcIn(pcIn),
      .wbIn(wbIn), .rDstIn(rDstIn), .aluDataOut(aluDataOut), .memoryDataOut(memoryDataOut),
      .memoryReadOut(memoryReadOut), .wbOut(wbOut), .rDstOut(rDstOut),
      .writePcLowOut(writePcLowOut), .writePcHighOut(writePcHighOut), .stall(stall), .spOut(spOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
      compared++;
      assert (o === e) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", t, o, e);
      end
   endtask

   task automatic outs(input string t, input logic [15:0] d, input bit dk, input bit rd,
                       input bit lo, input bit hi, input bit st, input bit wb);
      chk({t, ":sp"}, {21'd0, spOut}, sp);
      chk({t, ":alu"}, {16'd0, aluDataOut}, {16'd0, aluData});
      chk({t, ":rdst"}, {29'd0, rDstOut}, {29'd0, rDstIn});
      if (dk) chk({t, ":data"}, {16'd0, memoryDataOut}, {16'd0, d});
      chk({t, ":rdv"}, {31'd0, memoryReadOut}, {31'd0, rd});
      chk({t, ":pclo"}, {31'd0, writePcLowOut}, {31'd0, lo});
      chk({t, ":pchi"}, {31'd0, writePcHighOut}, {31'd0, hi});
      chk({t, ":stall"}, {31'd0, stall}, {31'd0, st});
      chk({t, ":wb"}, {31'd0, wbOut}, {31'd0, wb});
   endtask

   task automatic set(input logic [5:0] c, input bit wb);
      {pcPop, pcPush, pop, push, memWrite, memRead} = c;
      wbIn = wb;
      rDstIn = 3'($urandom);
      aluData = 16'($urandom);
      storeData = 16'($urandom);
      pcIn = $urandom;
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset;
      rst = 1'b1;
      set(6'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      sp = 2047;
   endtask

   task automatic opRead(input logic [15:0] a, input bit wb);
      int i;
      i = int'(a) & 2047;
      set(6'b000001, wb);
      aluData = a;
      #1 outs("read", mm[i], kn[i], 1, 0, 0, 0, wb);
      tick;
   endtask

   task automatic opWrite(input logic [15:0] a, input logic [15:0] d, input bit wb);
      int i;
      i = int'(a) & 2047;
      set(6'b000010, wb);
      aluData = a;
      storeData = d;
      #1 outs("write", 16'h0, 1, 0, 0, 0, 0, wb);
      tick;
      mm[i] = d;
      kn[i] = 1;
   endtask

   task automatic opPush(input logic [15:0] d, input bit wb);
      set(6'b000100, wb);
      storeData = d;
      #1 outs("push", 16'h0, 1, 0, 0, 0, 0, wb);
      tick;
      mm[sp] = d;
      kn[sp] = 1;
      sp = (sp - 1) & 2047;
   endtask

   task automatic opPop(input bit wb);
      int i;
      i = (sp + 1) & 2047;
      set(6'b001000, wb);
      #1 outs("pop", mm[i], kn[i], 1, 0, 0, 0, wb);
      tick;
      sp = i;
   endtask

   task automatic opPcPush(input logic [31:0] pc, input bit wb);
      set(6'b010000, wb);
      pcIn = pc;
      #1 outs("pcpush1", 16'h0, 1, 0, 0, 0, 1, 0);
      tick;
      mm[sp] = pc[31:16];
      kn[sp] = 1;
      sp = (sp - 1) & 2047;
      outs("pcpush2", 16'h0, 1, 0, 0, 0, 0, 0);
      tick;
      mm[sp] = pc[15:0];
      kn[sp] = 1;
      sp = (sp - 1) & 2047;
   endtask

   task automatic opPcPop(input bit wb);
      int i;
      i = (sp + 1) & 2047;
      set(6'b100000, wb);
      #1 outs("pcpop1", mm[i], kn[i], 1, 1, 0, 1, 0);
      tick;
      sp = i;
      i = (sp + 1) & 2047;
      outs("pcpop2", mm[i], kn[i], 1, 0, 1, 0, 0);
      tick;
      sp = i;
   endtask

   initial begin
      int k;
      doReset;
      #1 outs("reset", 16'h0, 1, 0, 0, 0, 0, 0);
      opWrite(16'h0010, 16'hBEEF, 1);
      opRead(16'h0010, 1);
      opRead(16'hF810, 0);
      opPush(16'h1234, 1);
      opPop(1);
      opPcPush(32'h0001_2345, 1);
      opRead(16'h07FF, 0);
      opRead(16'h07FE, 0);
      opPcPush(32'h0001_2345, 1);
      opPcPop(1);
      opWrite(16'h0000, 16'h5555, 0);
      doReset;
      opPop(1);
      opPush(16'hAAAA, 1);
      opRead(16'h0000, 1);
      opWrite(16'h07FE, 16'hCAFE, 0);
      doReset;
      set(6'b010000, 1);
      pcIn = 32'h0BAD_F00D;
      #1 outs("rstpush1", 16'h0, 1, 0, 0, 0, 1, 0);
      tick;
      mm[sp] = 16'h0BAD;
      kn[sp] = 1;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      sp = 2047;
      set(6'b0, 0);
      #1 outs("postrst", 16'h0, 1, 0, 0, 0, 0, 0);
      opRead(16'h07FE, 0);
      opRead(16'h07FF, 0);
      for (int n = 0; n < 400; n++) begin
         k = int'($urandom_range(0, 9));
         case (k)
            0, 1:    opRead(16'($urandom), 1'($urandom));
            2, 3:    opWrite(16'($urandom), 16'($urandom), 1'($urandom));
            4, 5:    opPush(16'($urandom), 1'($urandom));
            6, 7:    opPop(1'($urandom));
            8:       opPcPush($urandom, 1'($urandom));
            default: opPcPop(1'($urandom));
         endcase
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
